keypad_entry_ctrl: RTL and testbench

- Scans a 4x4 active-low matrix keypad, debounces each press and turns it into one key event.
- Sequences a 32-bit hex entry buffer: shift-in, backspace, clear and enter.
- Hands the committed word to the CPU input path with a valid/ready handshake.
- Sits between the board keypad pins and the CPU's keyboard input register, and replaces the unclocked key-driven buffer with a clocked controller.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner.sv | 116 +++++++++++
 rtl/keypad_entry_ctrl.sv | 94 +++++++++
 tb/tb_keypad_entry_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, scan FSM encoding and buffer sizing for the keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_BKSP = 4'hC;
    localparam logic [3:0] KEY_CLR  = 4'hE;
    localparam logic [3:0] KEY_ENT  = 4'hF;

    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        APPLY,
        RELEASE
    } scan_state_t;

    // Lowest-numbered active-low column wins when several are pressed together.
    function automatic logic [1:0] lowest_low_col(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd3;
        if (!pat[2]) idx = 2'd2;
        if (!pat[1]) idx = 2'd1;
        if (!pat[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanning, column synchronisation and press/release debounce for a 4x4 keypad.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_pulse,
    output logic [3:0] key_code
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    scan_state_t   state_q, state_d;
    logic [3:0]    col_s1_q, col_s1_d;
    logic [3:0]    col_s2_q, col_s2_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic          key_pulse_q, key_pulse_d;
    logic [3:0]    key_code_q, key_code_d;

    always_comb begin
        state_d     = state_q;
        col_s1_d    = col_n;
        col_s2_d    = col_s1_q;
        row_idx_d   = row_idx_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        key_pulse_d = 1'b0;
        key_code_d  = key_code_q;

        unique case (state_q)
            SCAN: begin
                if (col_s2_q != 4'hF) begin
                    pat_d      = col_s2_q;
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    state_d    = DEBOUNCE;
                end else if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    row_idx_d  = row_idx_q + 2'd1;
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            DEBOUNCE: begin
                // A bounce drops back to scanning on the same row rather than skipping it.
                if (col_s2_q != pat_q) begin
                    state_d = SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = APPLY;
                    key_pulse_d = 1'b1;
                    key_code_d  = {row_idx_q, lowest_low_col(pat_q)};
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            APPLY: begin
                deb_cnt_d = '0;
                state_d   = RELEASE;
            end
            RELEASE: begin
                if (col_s2_q != 4'hF) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    row_idx_d  = row_idx_q + 2'd1;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= SCAN;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            row_idx_q   <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            pat_q       <= 4'hF;
            key_pulse_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_s1_q    <= col_s1_d;
            col_s2_q    <= col_s2_d;
            row_idx_q   <= row_idx_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pat_q       <= pat_d;
            key_pulse_q <= key_pulse_d;
            key_code_q  <= key_code_d;
        end
    end

    assign row_n     = ~(4'b0001 << row_idx_q);
    assign key_pulse = key_pulse_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad front end: turns debounced key events into a hex entry buffer and a valid/ready commit.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [31:0] live_data,
    output logic [3:0]  digit_cnt,
    output logic        key_pulse,
    output logic [3:0]  key_code,
    output logic [31:0] commit_data,
    output logic        commit_valid,
    input  logic        commit_ready
);

    logic [31:0] live_q, live_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cdata_q, cdata_d;
    logic        cvalid_q, cvalid_d;

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_scanner (
        .clk       (clk),
        .rstn      (rstn),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_pulse (key_pulse),
        .key_code  (key_code)
    );

    always_comb begin
        live_d   = live_q;
        cnt_d    = cnt_q;
        cdata_d  = cdata_q;
        cvalid_d = cvalid_q;

        if (cvalid_q && commit_ready) cvalid_d = 1'b0;

        if (key_pulse) begin
            unique case (key_code)
                KEY_BKSP: begin
                    live_d = live_q >> 4;
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                end
                KEY_CLR: begin
                    live_d = '0;
                    cnt_d  = 4'd0;
                end
                KEY_ENT: begin
                    // A transfer on this same edge frees the slot for the new word.
                    if (!cvalid_q || commit_ready) begin
                        cdata_d  = live_q;
                        cvalid_d = 1'b1;
                        live_d   = '0;
                        cnt_d    = 4'd0;
                    end
                end
                default: begin
                    if (cnt_q < 4'(MAX_DIGITS)) begin
                        live_d = {live_q[27:0], key_code};
                        cnt_d  = cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            live_q   <= '0;
            cnt_q    <= 4'd0;
            cdata_q  <= '0;
            cvalid_q <= 1'b0;
        end else begin
            live_q   <= live_d;
            cnt_q    <= cnt_d;
            cdata_q  <= cdata_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign live_data    = live_q;
    assign digit_cnt    = cnt_q;
    assign commit_data  = cdata_q;
    assign commit_valid = cvalid_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomised bench for keypad_entry_ctrl with a behavioural keypad and entry-buffer model.
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [31:0] live_data;
    logic [3:0]  digit_cnt;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic [31:0] commit_data;
    logic        commit_valid;
    logic        commit_ready;

    bit          key_down = 1'b0;
    logic [1:0]  key_r = 2'd0;
    logic [1:0]  key_c = 2'd0;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulse_cnt = 0;

    logic [31:0] m_val = '0;
    int          m_n = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_word = '0;

    keypad_entry_ctrl #(
        .SCAN_DIV   (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .col_n        (col_n),
        .row_n        (row_n),
        .live_data    (live_data),
        .digit_cnt    (digit_cnt),
        .key_pulse    (key_pulse),
        .key_code     (key_code),
        .commit_data  (commit_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready)
    );

    always #5 clk = ~clk;

    // Physical keypad: the pressed switch shorts its column to its row only while that row is driven low.
    always_comb begin
        col_n = 4'hF;
        if (key_down && !row_n[key_r]) col_n[key_c] = 1'b0;
    end

    always @(posedge clk) if (key_pulse) pulse_cnt++;

    task automatic model_key(input logic [3:0] code, input bit rdy);
        if (code == KEY_ENT) begin
            if (!m_pend || rdy) begin
                m_word = m_val;
                m_pend = 1'b1;
                m_val  = 0;
                m_n    = 0;
            end
        end else begin
            if (rdy) m_pend = 1'b0;
            if (code == KEY_BKSP) begin
                m_val = m_val / 16;
                if (m_n > 0) m_n--;
            end else if (code == KEY_CLR) begin
                m_val = 0;
                m_n   = 0;
            end else if (m_n < 8) begin
                m_val = m_val * 16 + 32'(code);
                m_n++;
            end
        end
    endtask

    task automatic press(input logic [3:0] code, input bit rdy, input int hold_after,
                         output bit got, output logic [3:0] code_seen);
        got       = 1'b0;
        code_seen = 4'hx;
        key_r     = code[3:2];
        key_c     = code[1:0];
        key_down  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (key_pulse) begin
                got       = 1'b1;
                code_seen = key_code;
            end
        end
        if (got) begin
            commit_ready = rdy;
            @(negedge clk);
            commit_ready = 1'b0;
        end
        repeat (hold_after) @(negedge clk);
        key_down = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        commit_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({row_n, live_data, digit_cnt, key_pulse, key_code, commit_data, commit_valid} !==
            {4'b1110, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: row_n=%b live=%h cnt=%0d valid=%b", row_n, live_data, digit_cnt, commit_valid);
        end
        rstn = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] exp_row;
            exp_row = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            vectors++;
            if (row_n !== exp_row || key_pulse !== 1'b0 || commit_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL row_rotation k=%0d: row_n=%b expected %b", k, row_n, exp_row);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_press;
        bit got;
        logic [3:0] seen;
        int p0;
        p0 = pulse_cnt;
        key_r = 2'd2;
        key_c = 2'd1;
        key_down = 1'b1;
        repeat (3) @(negedge clk);
        key_down = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (pulse_cnt !== p0) begin
            miscompares++;
            $display("[TB] FAIL glitch_pulse: got %0d pulses expected 0", pulse_cnt - p0);
        end
        p0 = pulse_cnt;
        press(4'h6, 1'b0, 20, got, seen);
        model_key(4'h6, 1'b0);
        vectors++;
        if (!got || seen !== 4'h6 || pulse_cnt - p0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL press6: code=%h pulses=%0d expected code 6 pulses 1", seen, pulse_cnt - p0);
        end
        vectors++;
        if (live_data !== 32'h6 || digit_cnt !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL press6_buffer: live=%h cnt=%0d expected 6 cnt 1", live_data, digit_cnt);
        end
    endtask

    task automatic test_edit;
        logic [3:0] seq [14];
        bit got;
        logic [3:0] seen;
        int p0;
        seq = '{4'hE, 4'h1, 4'h2, 4'h3, 4'hC, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
        for (int i = 0; i < 14; i++) begin
            p0 = pulse_cnt;
            press(seq[i], 1'b0, 2, got, seen);
            model_key(seq[i], 1'b0);
            vectors++;
            if (!got || seen !== seq[i] || pulse_cnt - p0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL edit_key[%0d]: code=%h pulses=%0d expected %h x1", i, seen, pulse_cnt - p0, seq[i]);
            end
            vectors++;
            if (live_data !== m_val || digit_cnt !== 4'(m_n)) begin
                miscompares++;
                $display("[TB] FAIL edit_buf[%0d]: live=%h cnt=%0d expected %h cnt %0d", i, live_data, digit_cnt, m_val, m_n);
            end
            if (i == 3 || i == 4 || i == 13) begin
                logic [31:0] want;
                want = (i == 3) ? 32'h123 : (i == 4) ? 32'h12 : 32'h12AAAAAA;
                vectors++;
                if (live_data !== want) begin
                    miscompares++;
                    $display("[TB] FAIL edit_milestone[%0d]: live=%h expected %h", i, live_data, want);
                end
            end
        end
    endtask

    task automatic test_commit;
        logic [3:0] seq [5];
        bit got;
        logic [3:0] seen;
        seq = '{4'hE, 4'h1, 4'h2, 4'hF, 4'h5};
        for (int i = 0; i < 6; i++) begin
            logic [3:0] code;
            code = (i < 5) ? seq[i] : KEY_ENT;
            press(code, 1'b0, 2, got, seen);
            model_key(code, 1'b0);
            vectors++;
            if (!got || seen !== code || live_data !== m_val || digit_cnt !== 4'(m_n) ||
                commit_valid !== m_pend || commit_data !== m_word) begin
                miscompares++;
                $display("[TB] FAIL commit_step[%0d]: live=%h valid=%b cdata=%h expected %h %b %h",
                         i, live_data, commit_valid, commit_data, m_val, m_pend, m_word);
            end
        end
        vectors++;
        if (commit_data !== 32'h12 || live_data !== 32'h5 || commit_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL commit_hold: cdata=%h live=%h valid=%b expected 12 5 1", commit_data, live_data, commit_valid);
        end
        commit_ready = 1'b1;
        @(negedge clk);
        commit_ready = 1'b0;
        m_pend = 1'b0;
        vectors++;
        if (commit_valid !== 1'b0 || commit_data !== 32'h12) begin
            miscompares++;
            $display("[TB] FAIL commit_handshake: valid=%b cdata=%h expected 0 12", commit_valid, commit_data);
        end
    endtask

    task automatic test_back_to_back;
        bit got;
        logic [3:0] seen;
        press(KEY_ENT, 1'b0, 2, got, seen);
        model_key(KEY_ENT, 1'b0);
        press(4'h7, 1'b0, 2, got, seen);
        model_key(4'h7, 1'b0);
        press(KEY_ENT, 1'b1, 2, got, seen);
        model_key(KEY_ENT, 1'b1);
        vectors++;
        if (!got || commit_valid !== 1'b1 || commit_data !== 32'h7 || commit_data !== m_word || live_data !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: valid=%b cdata=%h live=%h expected 1 7 0", commit_valid, commit_data, live_data);
        end
    endtask

    task automatic test_random;
        bit got;
        logic [3:0] seen;
        int p0;
        for (int i = 0; i < 30; i++) begin
            logic [3:0] code;
            bit rdy;
            code = 4'($urandom_range(0, 15));
            rdy  = 1'($urandom_range(0, 1));
            p0 = pulse_cnt;
            press(code, rdy, $urandom_range(0, 6), got, seen);
            model_key(code, rdy);
            vectors++;
            if (!got || seen !== code || pulse_cnt - p0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL rand_key[%0d]: code=%h pulses=%0d expected %h x1", i, seen, pulse_cnt - p0, code);
            end
            vectors++;
            if (live_data !== m_val || digit_cnt !== 4'(m_n) || commit_valid !== m_pend || commit_data !== m_word) begin
                miscompares++;
                $display("[TB] FAIL rand_state[%0d]: live=%h cnt=%0d valid=%b cdata=%h expected %h %0d %b %h",
                         i, live_data, digit_cnt, commit_valid, commit_data, m_val, m_n, m_pend, m_word);
            end
            if ($urandom_range(0, 3) == 0) begin
                commit_ready = 1'b1;
                @(negedge clk);
                commit_ready = 1'b0;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_op;
        bit got;
        logic [3:0] seen;
        int run;
        int p0;
        press(4'h9, 1'b0, 2, got, seen);
        model_key(4'h9, 1'b0);
        press(KEY_ENT, 1'b0, 2, got, seen);
        model_key(KEY_ENT, 1'b0);
        vectors++;
        if (commit_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_valid: valid=%b expected 1", commit_valid);
        end
        key_r = 2'd1;
        key_c = 2'd2;
        key_down = 1'b1;
        run = 0;
        for (int i = 0; i < 100 && run < 5; i++) begin
            @(negedge clk);
            run = (row_n == 4'b1101) ? run + 1 : 0;
        end
        vectors++;
        if (run < 5) begin
            miscompares++;
            $display("[TB] FAIL debounce_wait: row hold count %0d expected 5", run);
        end
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({row_n, live_data, digit_cnt, key_pulse, key_code, commit_data, commit_valid} !==
            {4'b1110, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL midop_reset: row_n=%b live=%h key_code=%h valid=%b cdata=%h",
                     row_n, live_data, key_code, commit_valid, commit_data);
        end
        key_down = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        m_val = 0; m_n = 0; m_pend = 1'b0; m_word = 0;
        p0 = pulse_cnt;
        repeat (40) @(negedge clk);
        vectors++;
        if (pulse_cnt !== p0) begin
            miscompares++;
            $display("[TB] FAIL aborted_press: got %0d pulses expected 0", pulse_cnt - p0);
        end
        press(4'h6, 1'b0, 2, got, seen);
        model_key(4'h6, 1'b0);
        vectors++;
        if (!got || seen !== 4'h6 || pulse_cnt - p0 !== 1 || live_data !== m_val || digit_cnt !== 4'(m_n)) begin
            miscompares++;
            $display("[TB] FAIL fresh_press: code=%h pulses=%0d live=%h expected 6 1 %h", seen, pulse_cnt - p0, live_data, m_val);
        end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_edit;
        test_commit;
        test_back_to_back;
        test_random;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
